// File: rtl/seg7_display_mux.sv
// Two-digit multiplexed 7-segment driver: holds a BCD units/tens pair on load and
// scans it as units, blank, tens, blank, with registered segment and anode outputs.
module seg7_display_mux #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bin_unit,
    input  logic [3:0] bin_ten,
    input  logic       load,
    input  logic       blank_zero,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_done
);

    localparam int MAX_DUR = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYCLES - 1);
    localparam logic [6:0]    SEG_OFF   = {7{ACTIVE_LOW}};
    localparam logic [1:0]    AN_OFF    = {2{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        SHOW_U = 2'd0,
        GAP_U  = 2'd1,
        SHOW_T = 2'd2,
        GAP_T  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      unit_q, unit_d;
    logic [3:0]      ten_q, ten_d;
    logic [6:0]      seg_q, seg_d;
    logic [1:0]      an_q, an_d;
    logic            frame_done_q, frame_done_d;

    logic            phase_last;
    logic [6:0]      seg_on;
    logic [1:0]      an_on;

    // Active-high pattern in {g,f,e,d,c,b,a}; anything above 9 shows a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        unit_d       = unit_q;
        ten_d        = ten_q;
        seg_on       = 7'b0000000;
        an_on        = 2'b00;

        if (load) begin
            unit_d = bin_unit;
            ten_d  = bin_ten;
        end

        if ((state_q == SHOW_U) || (state_q == SHOW_T)) begin
            phase_last = (cnt_q == SHOW_LAST);
        end else begin
            phase_last = (cnt_q == GAP_LAST);
        end

        if (phase_last) begin
            cnt_d = '0;
            case (state_q)
                SHOW_U:  state_d = GAP_U;
                GAP_U:   state_d = SHOW_T;
                SHOW_T:  state_d = GAP_T;
                default: state_d = SHOW_U;
            endcase
        end

        case (state_q)
            SHOW_U: begin
                an_on  = 2'b01;
                seg_on = bcd_to_seg(unit_q);
            end
            SHOW_T: begin
                // Leading-zero suppression only drops the anode; phase timing is untouched.
                an_on  = (blank_zero && (ten_q == 4'd0)) ? 2'b00 : 2'b10;
                seg_on = bcd_to_seg(ten_q);
            end
            default: begin
                an_on  = 2'b00;
                seg_on = 7'b0000000;
            end
        endcase

        seg_d        = seg_on ^ SEG_OFF;
        an_d         = an_on ^ AN_OFF;
        frame_done_d = (state_q == GAP_T) && phase_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SHOW_U;
            cnt_q        <= '0;
            unit_q       <= 4'd0;
            ten_q        <= 4'd0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            unit_q       <= unit_d;
            ten_q        <= ten_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_display_mux.sv
// Directed bench for seg7_display_mux: one active-high and one active-low instance
// share the stimulus; every cycle is checked against hand-written frame patterns.
module tb_seg7_display_mux;

    localparam logic [6:0] D0   = 7'b0111111;
    localparam logic [6:0] D1   = 7'b0000110;
    localparam logic [6:0] D2   = 7'b1011011;
    localparam logic [6:0] D3   = 7'b1001111;
    localparam logic [6:0] D7   = 7'b0000111;
    localparam logic [6:0] D9   = 7'b1101111;
    localparam logic [6:0] DASH = 7'b1000000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bin_unit;
    logic [3:0] bin_ten;
    logic       load;
    logic       blank_zero;
    logic [6:0] seg_p, seg_n;
    logic [1:0] an_p, an_n;
    logic       fd_p, fd_n;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    seg7_display_mux #(.REFRESH_DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(1'b0)) dut_p (
        .clk(clk), .rst(rst), .bin_unit(bin_unit), .bin_ten(bin_ten), .load(load),
        .blank_zero(blank_zero), .seg(seg_p), .an(an_p), .frame_done(fd_p)
    );

    seg7_display_mux #(.REFRESH_DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(1'b1)) dut_n (
        .clk(clk), .rst(rst), .bin_unit(bin_unit), .bin_ten(bin_ten), .load(load),
        .blank_zero(blank_zero), .seg(seg_n), .an(an_n), .frame_done(fd_n)
    );

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got{fd,an,seg}=%b_%b_%b exp=%b_%b_%b",
                     tag, cyc, got[9], got[8:7], got[6:0], exp[9], exp[8:7], exp[6:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Frame position p: 0-3 units, 4 gap, 5-8 tens, 9 gap with frame_done.
    task automatic check_cycle(input string tag, input int p, input logic [6:0] useg,
                               input logic [6:0] tseg, input logic t_on);
        logic [6:0] es;
        logic [1:0] ea;
        logic       ef;
        logic [6:0] mask;
        step();
        es   = 7'b0000000;
        ea   = 2'b00;
        ef   = 1'b0;
        mask = 7'h7F;
        if (p < 4) begin
            es = useg;
            ea = 2'b01;
        end else if (p >= 5 && p <= 8) begin
            es = tseg;
            ea = t_on ? 2'b10 : 2'b00;
            if (!t_on) mask = 7'h00;
        end else if (p == 9) begin
            ef = 1'b1;
        end
        chk({tag, "_hi"}, {fd_p, an_p, seg_p & mask}, {ef, ea, es & mask});
        chk({tag, "_lo"}, {fd_n, an_n, seg_n & mask}, {ef, ~ea, ~es & mask});
    endtask

    task automatic run_frame(input string tag, input logic [6:0] useg, input logic [6:0] tseg,
                             input logic t_on, input logic do_load, input logic [3:0] nu,
                             input logic [3:0] nt, input logic nbz, input logic scramble);
        for (int p = 0; p < 10; p++) begin
            if (scramble) begin
                bin_unit = 4'($urandom_range(0, 15));
                bin_ten  = 4'($urandom_range(0, 15));
            end
            if (p == 9) begin
                blank_zero = nbz;
                if (do_load) begin
                    load     = 1'b1;
                    bin_unit = nu;
                    bin_ten  = nt;
                end
            end
            check_cycle(tag, p, useg, tseg, t_on);
        end
        load = 1'b0;
        $display("frame %s checked at cyc=%0d errors=%0d", tag, cyc, n_errors);
    endtask

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        bin_unit   = 4'd0;
        bin_ten    = 4'd0;
        blank_zero = 1'b0;

        step();
        step();
        chk("reset_hi", {fd_p, an_p, seg_p}, {1'b0, 2'b00, 7'b0000000});
        chk("reset_lo", {fd_n, an_n, seg_n}, {1'b0, 2'b11, 7'b1111111});
        rst = 1'b0;

        // Held digits start at zero; load 23 for the following frame.
        run_frame("zero", D0, D0, 1'b1, 1'b1, 4'd3, 4'd2, 1'b0, 1'b0);
        run_frame("d23a", D3, D2, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        run_frame("d23b", D3, D2, 1'b1, 1'b1, 4'd9, 4'd0, 1'b1, 1'b0);

        run_frame("d09_bz1", D9, D0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        run_frame("d09_bz0", D9, D0, 1'b1, 1'b1, 4'd12, 4'd1, 1'b0, 1'b0);

        run_frame("inv12", DASH, D1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        run_frame("noload", DASH, D1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);

        // Load 7 mid units phase: the edge that captures still shows the old digit.
        for (int p = 0; p < 10; p++) begin
            load = (p == 2);
            if (p == 2) begin
                bin_unit = 4'd7;
                bin_ten  = 4'd1;
            end
            check_cycle("midload", p, (p >= 3) ? D7 : DASH, D1, 1'b1);
        end
        load = 1'b0;
        $display("frame midload checked at cyc=%0d errors=%0d", cyc, n_errors);

        // Reset in the middle of SHOW_T, with a simultaneous load that must lose.
        for (int p = 0; p < 6; p++) begin
            check_cycle("prerst", p, D7, D1, 1'b1);
        end
        rst      = 1'b1;
        load     = 1'b1;
        bin_unit = 4'd5;
        bin_ten  = 4'd5;
        step();
        chk("midrst_hi", {fd_p, an_p, seg_p}, {1'b0, 2'b00, 7'b0000000});
        chk("midrst_lo", {fd_n, an_n, seg_n}, {1'b0, 2'b11, 7'b1111111});
        rst  = 1'b0;
        load = 1'b0;
        run_frame("postrst", D0, D0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_display_mux.md
Name: seg7_display_mux

Overview:
- Consumes the two BCD digits (units, tens) produced by the binary-to-BCD converter and drives a two-digit multiplexed 7-segment display.
- Captures the digits into holding registers on a load strobe, so the display cannot tear mid-frame.
- Time-multiplexes the two digits with a blanking gap between them to suppress ghosting.
- Sits between the ALU result path (via the converter) and the board's display pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit is driven per frame; must be >= 1.
- BLANK_CYCLES, 500, clock cycles with all digits off between digit phases; must be >= 1.
- ACTIVE_LOW, 1, polarity of seg and an: 1 means low lights the segment or digit (common-anode board), 0 means high lights it.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- bin_unit  input  4  units BCD digit from the converter.
- bin_ten  input  4  tens BCD digit from the converter.
- load  input  1  when high at a clk edge, both digits are captured into the holding registers.
- blank_zero  input  1  when 1, a held tens digit of 0 is not lit (leading-zero suppression).
- seg  output  7  segment drive, bit order {g,f,e,d,c,b,a}.
- an  output  2  digit enables; an[0] is units, an[1] is tens.
- frame_done  output  1  one-cycle pulse at the end of each full frame.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - While rst=1: holding registers clear to 0, FSM goes to SHOW_U, phase counter clears to 0, frame_done=0.
  - While rst=1, seg and an are all-off: for ACTIVE_LOW=1, seg=7'h7F and an=2'b11; for ACTIVE_LOW=0, all zeros.
  - rst asserted mid-frame aborts the frame immediately; no frame_done is generated.
- FSM states: SHOW_U -> GAP_U -> SHOW_T -> GAP_T -> SHOW_U.
  - SHOW_U and SHOW_T each last REFRESH_DIV cycles.
  - GAP_U and GAP_T each last BLANK_CYCLES cycles.
  - The phase counter counts 0 to (duration-1), then clears as the state advances.
  - Frame period is 2*(REFRESH_DIV+BLANK_CYCLES) cycles.
- Outputs are registered and reflect the current state and held digits with 1 cycle of latency.
  - The first post-reset cycle shows all-off.
  - The second post-reset cycle shows units=0 lit.
- Digit drive:
  - SHOW_U enables an[0] only and shows the held units digit.
  - SHOW_T enables an[1] only and shows the held tens digit.
  - GAP states drive all-off on both seg and an.
- Leading-zero suppression: in SHOW_T, if blank_zero=1 and held tens=0, an stays all-off for that phase; phase timing is unchanged.
- Load:
  - Holding registers update on every edge where load=1; load held high tracks the inputs continuously.
  - load has no effect on FSM state or counter.
  - A new value is visible on seg at the edge after capture, starting with the next cycle of the digit currently displayed.
- Decode, shown active-high in {g..a} order (invert all bits when ACTIVE_LOW=1):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Values 10-15 are not valid BCD and display a dash, 1000000 (segment g only).
- frame_done is high for exactly the one cycle in which the output reflects the last cycle of GAP_T. It is 0 at all other times.
- If rst and load are high together, reset wins and the holding registers become 0.

Test Plan:
All scenarios use REFRESH_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=0.
1. Reset, then load units=3 and tens=2 (decimal 23), blank_zero=0. Required, repeating every 10 cycles:
   - 4 cycles of an=01, seg=1001111
   - 1 cycle of an=00, seg=0000000
   - 4 cycles of an=10, seg=1011011
   - 1 cycle all-off with frame_done=1
2. Load units=9, tens=0:
   - blank_zero=1: the tens phase shows an=00; the units phase shows an=01, seg=1101111.
   - blank_zero=0: the tens phase shows an=10, seg=0111111.
3. Load units=12, tens=1 (invalid units digit). Required: units phase seg=1000000; tens phase seg=0000110.
4. Hold load=0 and change bin_unit/bin_ten every cycle. Required: the displayed digits never change. Then pulse load for 1 cycle with units=7: the units phase shows 0000111 from the following frame, or from the next cycle if the units phase is currently active.
5. Assert rst for 1 cycle in the middle of SHOW_T. Required:
   - the next output is all-off;
   - then units=0 is shown for 4 cycles;
   - frame_done does not fire until 10 cycles after reset release.
6. Repeat scenario 1 with ACTIVE_LOW=1. Required: every seg and an value is the bitwise inverse of scenario 1; the reset state is seg=1111111, an=11.
